whack_score_keeper: RTL and testbench

Scoring and game-state stage that consumes the per-switch edge pulses and the current lit-LED mask of the whack-a-LED game. It judges each switch edge as a hit (its LED was lit) or a miss (its LED was dark), keeps a saturating 4-digit BCD score, a lives counter and a best-score register, and runs the IDLE/PLAY/OVER game state machine. It emits a per-bit clear mask that the LED driver applies instead of clearing on every edge.

---
 rtl/whack_score_keeper_pkg.sv | 18 +
 rtl/whack_score_keeper_bcd_counter4.sv | 55 +++++
 rtl/whack_score_keeper.sv | 110 +++++++++++
 tb/tb_whack_score_keeper.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/whack_score_keeper_pkg.sv
// Shared definitions for the whack-a-LED scoring stage: game states,
// the BCD score ceiling and the default lane count.
package whack_score_keeper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  localparam logic [15:0] BCD_MAX    = 16'h9999;
  localparam int          LANE_WIDTH = 18;

  function automatic logic [3:0] bcd_digit_inc(input logic [3:0] digit);
    return (digit == 4'd9) ? 4'd0 : digit + 4'd1;
  endfunction

endpackage

// File: rtl/whack_score_keeper_bcd_counter4.sv
// Four-digit packed-BCD incrementer with synchronous clear and saturation
// at 9999. count_next exposes the value the register will take this edge.
module whack_score_keeper_bcd_counter4
  import whack_score_keeper_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  output logic [15:0] count,
  output logic [15:0] count_next
);

  logic [15:0] count_reg;
  logic [15:0] incremented;
  logic [3:0]  carry;
  logic [2:0]  is_nine;

  // A digit advances only when every lower digit is about to wrap from 9.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      if (gi == 0) begin : g_lsd
        assign carry[gi] = 1'b1;
      end else begin : g_upper
        assign carry[gi] = carry[gi-1] & is_nine[gi-1];
      end
      if (gi < 3) begin : g_nine
        assign is_nine[gi] = (count_reg[gi*4 +: 4] == 4'd9);
      end
      assign incremented[gi*4 +: 4] = carry[gi] ? bcd_digit_inc(count_reg[gi*4 +: 4])
                                                : count_reg[gi*4 +: 4];
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable && (count_reg != BCD_MAX)) begin
      count_next = incremented;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/whack_score_keeper.sv
// Judges switch edges against the lit-LED mask, keeps score, lives and best
// score, and runs the IDLE/PLAY/OVER game state machine.
module whack_score_keeper
  import whack_score_keeper_pkg::*;
#(
  parameter int WIDTH = LANE_WIDTH,
  parameter int LIVES = 3
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] edge_detect,
  input  logic [WIDTH-1:0] led_mask,
  output logic [WIDTH-1:0] clear_mask,
  output logic             hit_pulse,
  output logic             miss_pulse,
  output logic [15:0]      score_bcd,
  output logic [15:0]      best_bcd,
  output logic [2:0]       lives,
  output logic             game_active,
  output logic             game_over
);

  localparam logic [2:0] LIVES_INIT = LIVES[2:0];

  game_state_t      state_reg;
  logic [WIDTH-1:0] clear_mask_reg;
  logic             hit_pulse_reg;
  logic             miss_pulse_reg;
  logic [15:0]      best_reg;
  logic [2:0]       lives_reg;
  logic             game_active_reg;
  logic             game_over_reg;

  logic [WIDTH-1:0] hits;
  logic [WIDTH-1:0] misses;
  logic             any_hit;
  logic             any_miss;
  logic             reload;
  logic [2:0]       lives_after;
  logic [15:0]      score_next;

  // Edges only count while playing; any number of lanes costs at most one point/life.
  assign hits        = edge_detect & led_mask;
  assign misses      = edge_detect & ~led_mask;
  assign any_hit     = (state_reg == PLAY) && (|hits);
  assign any_miss    = (state_reg == PLAY) && (|misses);
  assign reload      = start && (state_reg != PLAY);
  assign lives_after = lives_reg - {2'b00, any_miss};

  whack_score_keeper_bcd_counter4 u_score (
    .CLOCK_50   (CLOCK_50),
    .rst        (rst),
    .clear      (reload),
    .enable     (any_hit),
    .count      (score_bcd),
    .count_next (score_next)
  );

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_reg       <= IDLE;
      clear_mask_reg  <= '0;
      hit_pulse_reg   <= 1'b0;
      miss_pulse_reg  <= 1'b0;
      best_reg        <= '0;
      lives_reg       <= '0;
      game_active_reg <= 1'b0;
      game_over_reg   <= 1'b0;
    end else begin
      clear_mask_reg <= '0;
      hit_pulse_reg  <= 1'b0;
      miss_pulse_reg <= 1'b0;
      unique case (state_reg)
        PLAY: begin
          clear_mask_reg <= hits;
          hit_pulse_reg  <= any_hit;
          miss_pulse_reg <= any_miss;
          lives_reg      <= lives_after;
          if (lives_after == 3'd0) begin
            state_reg       <= OVER;
            game_active_reg <= 1'b0;
            game_over_reg   <= 1'b1;
            // Use the post-hit score so a hit on the final cycle still counts.
            if (score_next > best_reg) begin
              best_reg <= score_next;
            end
          end
        end
        default: begin
          if (reload) begin
            state_reg       <= PLAY;
            lives_reg       <= LIVES_INIT;
            game_active_reg <= 1'b1;
            game_over_reg   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign clear_mask  = clear_mask_reg;
  assign hit_pulse   = hit_pulse_reg;
  assign miss_pulse  = miss_pulse_reg;
  assign best_bcd    = best_reg;
  assign lives       = lives_reg;
  assign game_active = game_active_reg;
  assign game_over   = game_over_reg;

endmodule

// File: tb/tb_whack_score_keeper.sv
// Self-checking bench: directed game scenarios plus randomized play, compared
// each cycle against a decimal-arithmetic model of the scoring rules.
module tb_whack_score_keeper;

  localparam int W = 18;
  localparam int NLIVES = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  edge_detect = '0;
  logic [W-1:0]  led_mask = '0;
  logic [W-1:0]  clear_mask;
  logic          hit_pulse;
  logic          miss_pulse;
  logic [15:0]   score_bcd;
  logic [15:0]   best_bcd;
  logic [2:0]    lives;
  logic          game_active;
  logic          game_over;

  int checks = 0;
  int errors = 0;

  // Model state: mode 0 = idle, 1 = playing, 2 = finished.
  int           m_mode = 0;
  int           m_score = 0;
  int           m_best = 0;
  int           m_lives = 0;
  logic [W-1:0] m_clear = '0;
  bit           m_hit = 0;
  bit           m_miss = 0;

  whack_score_keeper #(.WIDTH(W), .LIVES(NLIVES)) dut (
    .CLOCK_50    (clk),
    .rst         (rst),
    .start       (start),
    .edge_detect (edge_detect),
    .led_mask    (led_mask),
    .clear_mask  (clear_mask),
    .hit_pulse   (hit_pulse),
    .miss_pulse  (miss_pulse),
    .score_bcd   (score_bcd),
    .best_bcd    (best_bcd),
    .lives       (lives),
    .game_active (game_active),
    .game_over   (game_over)
  );

  always #10 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit s, input logic [W-1:0] e, input logic [W-1:0] l);
    logic [W-1:0] h;
    logic [W-1:0] m;
    m_clear = '0;
    m_hit   = 0;
    m_miss  = 0;
    if (r) begin
      m_mode = 0; m_score = 0; m_best = 0; m_lives = 0;
    end else if (m_mode == 1) begin
      h = e & l;
      m = e & ~l;
      m_clear = h;
      m_hit   = (h != 0);
      m_miss  = (m != 0);
      if (m_hit && m_score < 9999) m_score = m_score + 1;
      if (m_miss) m_lives = m_lives - 1;
      if (m_lives == 0) begin
        m_mode = 2;
        if (m_score > m_best) m_best = m_score;
      end
    end else if (s) begin
      m_mode = 1; m_score = 0; m_lives = NLIVES;
    end
  endtask

  task automatic step(input bit r, input bit s, input logic [W-1:0] e, input logic [W-1:0] l,
                      input bit verbose);
    rst = r; start = s; edge_detect = e; led_mask = l;
    @(posedge clk);
    model_update(r, s, e, l);
    #1;
    check("clear_mask", 32'(clear_mask), 32'(m_clear));
    check("hit_pulse", 32'(hit_pulse), 32'(m_hit));
    check("miss_pulse", 32'(miss_pulse), 32'(m_miss));
    check("score_bcd", 32'(score_bcd), 32'(to_bcd(m_score)));
    check("best_bcd", 32'(best_bcd), 32'(to_bcd(m_best)));
    check("lives", 32'(lives), 32'(m_lives));
    check("game_active", 32'(game_active), 32'(m_mode == 1));
    check("game_over", 32'(game_over), 32'(m_mode == 2));
    if (verbose)
      $display("txn rst=%0b start=%0b edge=%05h led=%05h -> clear=%05h hit=%0b miss=%0b score=%04h best=%04h lives=%0d act=%0b over=%0b",
               r, s, e, l, clear_mask, hit_pulse, miss_pulse, score_bcd, best_bcd, lives,
               game_active, game_over);
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 18'h00008, 18'h0000C, 0);
    $display("txn %0d hits -> score=%04h hit=%0b", n, score_bcd, hit_pulse);
  endtask

  initial begin
    logic [W-1:0] e;
    logic [W-1:0] l;
    // Reset state and the directed opening sequence.
    step(1, 0, '0, '0, 1);
    step(1, 0, '0, '0, 1);
    step(0, 0, 18'h00004, 18'h00004, 1);   // edges ignored in idle
    step(0, 1, '0, '0, 1);
    step(0, 0, 18'h00004, 18'h00004, 1);
    step(0, 0, 18'h00011, 18'h00001, 1);
    step(0, 1, '0, '0, 1);                 // start ignored while playing

    // Lose all lives, then confirm the finished game ignores edges and restarts.
    step(1, 0, '0, '0, 1);
    step(0, 1, '0, '0, 1);
    step(0, 0, 18'h00002, 18'h00002, 1);
    step(0, 0, 18'h00003, 18'h00000, 1);
    step(0, 0, 18'h00100, 18'h00000, 1);
    step(0, 0, 18'h00201, 18'h00001, 1);   // final miss with a hit
    step(0, 0, 18'h00001, 18'h00001, 1);
    step(0, 0, 18'h00010, 18'h00000, 1);
    step(0, 1, '0, '0, 1);
    step(0, 0, 18'h00001, 18'h00000, 1);

    // Randomized play including restarts and occasional resets.
    for (int i = 0; i < 400; i++) begin
      e = '0;
      if ($urandom_range(0, 2) == 0) e = W'(1) << $urandom_range(0, W-1);
      if ($urandom_range(0, 5) == 0) e = e | (W'(1) << $urandom_range(0, W-1));
      l = W'($urandom);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0, e, l, 1);
    end

    // BCD ripple carry and saturation.
    step(1, 0, '0, '0, 1);
    step(0, 1, '0, '0, 1);
    hits(999);
    hits(1);
    hits(8999);
    hits(2);
    step(0, 0, 18'h00001, 18'h00000, 1);
    step(0, 0, 18'h00001, 18'h00000, 1);
    step(0, 0, 18'h00003, 18'h00001, 1);

    // Reset mid-game with a nonzero score.
    step(0, 1, '0, '0, 1);
    hits(42);
    step(1, 0, 18'h00004, 18'h00004, 1);
    step(0, 0, '0, '0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
